// File: rtl/definitions.sv
// rtl/definitions.sv - shared types and constants for the pc_fetch stage
// Purpose: FSM state type, datapath widths and default branch-target LUT contents.
// Ports: none (package).
package definitions;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  // Absolute branch/jump targets; entry i = i*32 so targets land on 32-word blocks.
  localparam logic [PC_W-1:0] BRANCH_TGT [32] = '{
    10'd0,   10'd32,  10'd64,  10'd96,  10'd128, 10'd160, 10'd192, 10'd224,
    10'd256, 10'd288, 10'd320, 10'd352, 10'd384, 10'd416, 10'd448, 10'd480,
    10'd512, 10'd544, 10'd576, 10'd608, 10'd640, 10'd672, 10'd704, 10'd736,
    10'd768, 10'd800, 10'd832, 10'd864, 10'd896, 10'd928, 10'd960, 10'd992
  };

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - control/status bundle between decoder, testbench and pc_fetch
// Purpose: groups the fetch-control inputs and PC/status outputs.
// Signals: Start, Branch, Jump, Halt, Zero, Target[4:0] (to fetch stage);
//          PC[PC_W-1:0], Done, CycleCnt[CNT_W-1:0] (from fetch stage).
// Modports: master drives control and observes status; slave is the fetch stage.
interface pc_fetch_if;
  import definitions::*;

  logic             Start;
  logic             Branch;
  logic             Jump;
  logic             Halt;
  logic             Zero;
  logic [4:0]       Target;
  logic [PC_W-1:0]  PC;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;

  modport master (
    output Start, Branch, Jump, Halt, Zero, Target,
    input  PC, Done, CycleCnt
  );

  modport slave (
    input  Start, Branch, Jump, Halt, Zero, Target,
    output PC, Done, CycleCnt
  );

endinterface

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational branch-target lookup
// Purpose: maps a 5-bit instruction immediate to an absolute PC_W-bit target.
// Ports: i_target[4:0] LUT index; o_addr[PC_W-1:0] target address.
module branch_lut
  import definitions::*;
(
  input  logic [4:0]      i_target,
  output logic [PC_W-1:0] o_addr
);

  assign o_addr = BRANCH_TGT[i_target];

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and run/halt fetch control
// Purpose: next-PC selection (halt/jump/branch/increment), IDLE/RUN/HALTED FSM,
//          optional RUN-cycle counter enabled by macro PC_CYCLE_COUNT_EN.
// Ports: Clk rising-edge clock; Reset async active-high;
//        bus (pc_fetch_if.slave): Start/Branch/Jump/Halt/Zero/Target in,
//        PC/Done/CycleCnt out (all registered; CycleCnt tied 0 without the macro).
module pc_fetch
  import definitions::*;
(
  input logic       Clk,
  input logic       Reset,
  pc_fetch_if.slave bus
);

  pc_state_e       r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_done;
  logic [PC_W-1:0] w_lut_pc;
  logic [PC_W-1:0] w_next_pc;

  branch_lut u_branch_lut (
    .i_target (bus.Target),
    .o_addr   (w_lut_pc)
  );

  // Jump outranks a branch and ignores Zero; the increment wraps naturally at 2^PC_W.
  always_comb begin
    w_next_pc = r_pc + PC_W'(1);
    if (bus.Jump) begin
      w_next_pc = w_lut_pc;
    end else if (bus.Branch && bus.Zero) begin
      w_next_pc = w_lut_pc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          // Halt has top priority and freezes the PC on the halting instruction.
          if (bus.Halt) begin
            r_state <= HALTED;
            r_done  <= 1'b1;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        HALTED: begin
          if (bus.Start) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pc    <= '0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC   = r_pc;
  assign bus.Done = r_done;

`ifdef PC_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Counts every edge spent in RUN (including the halting edge); saturates instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cycle_cnt <= '0;
    end else if (r_state != RUN && bus.Start) begin
      r_cycle_cnt <= '0;
    end else if (r_state == RUN && r_cycle_cnt != CNT_MAX) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign bus.CycleCnt = r_cycle_cnt;
`else
  assign bus.CycleCnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;
  import definitions::*;

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;

  pc_fetch_if bus_if ();

  pc_fetch u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus_if.Start  = 1'b0;
    bus_if.Branch = 1'b0;
    bus_if.Jump   = 1'b0;
    bus_if.Halt   = 1'b0;
    bus_if.Zero   = 1'b0;
    bus_if.Target = 5'd0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    Reset = 1'b1;
    step();
    step();
    n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", bus_if.PC); end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL idle_pc[%0d]: got %0d expected 0", i, bus_if.PC); end
      n_tests++; if (bus_if.Done !== 1'b0) begin n_fail++; $display("FAIL idle_done[%0d]: got %b expected 0", i, bus_if.Done); end
      n_tests++; if (bus_if.CycleCnt !== 16'd0) begin n_fail++; $display("FAIL idle_cnt[%0d]: got %0d expected 0", i, bus_if.CycleCnt); end
    end
  endtask

  task automatic test_sequential();
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
    n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL seq_start_pc: got %0d expected 0", bus_if.PC); end
    for (int i = 1; i <= 5; i++) begin
      step();
      n_tests++; if (bus_if.PC !== 10'(i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %0d expected %0d", i, bus_if.PC, i); end
    end
  endtask

  task automatic test_reset_mid_run();
    step();
    step();
    n_tests++; if (bus_if.PC !== 10'd7) begin n_fail++; $display("FAIL mid_run_pc: got %0d expected 7", bus_if.PC); end
    Reset = 1'b1;
    #1;
    n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL async_reset_pc: got %0d expected 0", bus_if.PC); end
    n_tests++; if (bus_if.Done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", bus_if.Done); end
    step();
    Reset = 1'b0;
    step();
    step();
    n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL reset_to_idle_pc: got %0d expected 0", bus_if.PC); end
  endtask

  task automatic test_branch();
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_tests++; if (bus_if.PC !== 10'd10) begin n_fail++; $display("FAIL branch_setup_pc: got %0d expected 10", bus_if.PC); end
    bus_if.Branch = 1'b1; bus_if.Zero = 1'b1; bus_if.Target = 5'd3;
    step();
    n_tests++; if (bus_if.PC !== 10'd96) begin n_fail++; $display("FAIL branch_taken: got %0d expected 96", bus_if.PC); end
    bus_if.Zero = 1'b0;
    step();
    n_tests++; if (bus_if.PC !== 10'd97) begin n_fail++; $display("FAIL branch_not_taken: got %0d expected 97", bus_if.PC); end
    clear_ctrl();
  endtask

  task automatic test_jump_halt();
    bus_if.Jump = 1'b1; bus_if.Target = 5'd1;
    step();
    clear_ctrl();
    n_tests++; if (bus_if.PC !== 10'd32) begin n_fail++; $display("FAIL jump_lut1: got %0d expected 32", bus_if.PC); end
    for (int i = 0; i < 8; i++) step();
    n_tests++; if (bus_if.PC !== 10'd40) begin n_fail++; $display("FAIL jump_setup_pc: got %0d expected 40", bus_if.PC); end
    bus_if.Jump = 1'b1; bus_if.Branch = 1'b1; bus_if.Zero = 1'b0; bus_if.Target = 5'd31;
    step();
    n_tests++; if (bus_if.PC !== 10'd992) begin n_fail++; $display("FAIL jump_over_branch: got %0d expected 992", bus_if.PC); end
    bus_if.Branch = 1'b0; bus_if.Halt = 1'b1; bus_if.Target = 5'd2;
    step();
    clear_ctrl();
    n_tests++; if (bus_if.PC !== 10'd992) begin n_fail++; $display("FAIL halt_over_jump_pc: got %0d expected 992", bus_if.PC); end
    n_tests++; if (bus_if.Done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b expected 1", bus_if.Done); end
    bus_if.Jump = 1'b1; bus_if.Branch = 1'b1; bus_if.Zero = 1'b1; bus_if.Target = 5'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (bus_if.PC !== 10'd992) begin n_fail++; $display("FAIL halted_pc[%0d]: got %0d expected 992", i, bus_if.PC); end
      n_tests++; if (bus_if.Done !== 1'b1) begin n_fail++; $display("FAIL halted_done[%0d]: got %b expected 1", i, bus_if.Done); end
    end
    clear_ctrl();
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
    n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL restart_pc: got %0d expected 0", bus_if.PC); end
    n_tests++; if (bus_if.Done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b expected 0", bus_if.Done); end
  endtask

  task automatic test_start_ignored();
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
    n_tests++; if (bus_if.PC !== 10'd1) begin n_fail++; $display("FAIL start_in_run: got %0d expected 1", bus_if.PC); end
  endtask

  task automatic test_wrap();
    bus_if.Jump = 1'b1; bus_if.Target = 5'd31;
    step();
    clear_ctrl();
    for (int i = 0; i < 31; i++) step();
    n_tests++; if (bus_if.PC !== 10'd1023) begin n_fail++; $display("FAIL wrap_setup_pc: got %0d expected 1023", bus_if.PC); end
    step();
    n_tests++; if (bus_if.PC !== 10'd0) begin n_fail++; $display("FAIL wrap_pc: got %0d expected 0", bus_if.PC); end
    n_tests++; if (bus_if.Done !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got %b expected 0", bus_if.Done); end
  endtask

  task automatic test_cycle_count();
    logic [15:0] exp_halt;
    logic [15:0] exp_sat;
`ifdef PC_CYCLE_COUNT_EN
    exp_halt = 16'd7;
    exp_sat  = 16'd65535;
`else
    exp_halt = 16'd0;
    exp_sat  = 16'd0;
`endif
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    clear_ctrl();
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
    n_tests++; if (bus_if.CycleCnt !== 16'd0) begin n_fail++; $display("FAIL cnt_start: got %0d expected 0", bus_if.CycleCnt); end
    for (int i = 0; i < 6; i++) step();
    bus_if.Halt = 1'b1;
    step();
    bus_if.Halt = 1'b0;
    n_tests++; if (bus_if.CycleCnt !== exp_halt) begin n_fail++; $display("FAIL cnt_halt: got %0d expected %0d", bus_if.CycleCnt, exp_halt); end
    n_tests++; if (bus_if.PC !== 10'd6) begin n_fail++; $display("FAIL cnt_halt_pc: got %0d expected 6", bus_if.PC); end
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (bus_if.CycleCnt !== exp_halt) begin n_fail++; $display("FAIL cnt_hold: got %0d expected %0d", bus_if.CycleCnt, exp_halt); end
    bus_if.Start = 1'b1;
    step();
    bus_if.Start = 1'b0;
    n_tests++; if (bus_if.CycleCnt !== 16'd0) begin n_fail++; $display("FAIL cnt_restart: got %0d expected 0", bus_if.CycleCnt); end
`ifdef PC_CYCLE_COUNT_EN
    for (int i = 0; i < 70000; i++) step();
`else
    for (int i = 0; i < 100; i++) step();
`endif
    n_tests++; if (bus_if.CycleCnt !== exp_sat) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected %0d", bus_if.CycleCnt, exp_sat); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset   = 1'b1;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_reset_mid_run();
    test_branch();
    test_jump_halt();
    test_start_ignored();
    test_wrap();
    test_cycle_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-control stage sitting directly downstream of the ALU. It consumes the ALU `Zero` flag together with decoder-supplied control and a 5-bit immediate. It produces the 10-bit instruction address that feeds instruction memory. Conditional branches (BEQ/BLT) and jumps resolve through a 32-entry absolute-target lookup table. A small run/halt state machine gives the testbench a start/done handshake.

## Interface
- `PC_W`, 10: PC and branch-target width.
- `CNT_W`, 16: cycle-counter width.
- `Clk`  input  1  rising-edge clock.
- `Reset`  input  1  asynchronous, active-high reset.
- `Start`  input  1  one-cycle pulse that begins or restarts program execution.
- `Branch`  input  1  decoder marks the current instruction as BEQ/BLT.
- `Jump`  input  1  decoder marks the current instruction as JUMP.
- `Halt`  input  1  decoder marks the current instruction as HALT.
- `Zero`  input  1  ALU zero flag; 1 means the branch condition is true.
- `Target`  input  5  LUT index, taken from the instruction immediate.
- `PC`  output  PC_W  current instruction address (registered).
- `Done`  output  1  high while halted (registered).
- `CycleCnt`  output  CNT_W  count of RUN cycles (see Configuration).

## Operation
- States: IDLE, RUN, HALTED.
- IDLE:
  - PC holds at 0, Done=0.
  - Start moves to RUN with PC=0.
- RUN: one update per cycle, first match wins:
  - Halt: go to HALTED, PC holds, Done←1.
  - Jump: PC←LUT[Target].
  - Branch && Zero: PC←LUT[Target] (taken).
  - otherwise: PC←PC+1, modulo 2^PC_W; 1023 wraps to 0.
  - Start in RUN is ignored.
  - Branch && !Zero is not taken, so PC←PC+1.
- HALTED:
  - PC frozen, Done=1.
  - Start returns to RUN with PC←0 and Done←0.
- Control inputs (Branch/Jump/Halt/Zero/Target) are don't-care outside RUN.
- Simultaneous events:
  - Halt+Jump: Halt wins.
  - Jump+Branch: Jump wins, and Zero is ignored.
- LUT entries are absolute addresses with default contents entry i = i×32, so LUT[0]=0, LUT[3]=96 and LUT[31]=992.

## Timing
- Reset, asynchronous, effective immediately and in any state: state=IDLE, PC=0, Done=0, CycleCnt=0.
- Reset mid-RUN aborts execution. There is no recovery of the PC.
- Single-cycle datapath: PC selects the instruction combinationally, and decode plus ALU settle within the cycle. Branch/Jump/Halt/Zero/Target are sampled on the same rising edge that updates PC.
- Latency is one cycle from the sampled edge to the new PC, for all cases. There are no delay slots and no bubbles.
- Start is sampled on the rising edge. On that edge: IDLE→RUN, or HALTED→RUN.
- Done:
  - rises on the edge that samples Halt;
  - falls on the edge that samples Start in HALTED.

## Configuration
- Macro `PC_CYCLE_COUNT_EN`.
- Defined:
  - CycleCnt increments on every rising edge where state is RUN, including the edge that samples Halt.
  - It saturates at 2^CNT_W−1 (no wrap).
  - It clears to 0 on the Start edge that enters RUN.
  - It holds in IDLE and HALTED.
- Undefined: the counter logic is absent and CycleCnt is tied to 0. The port list is unchanged.

## Structure
- Shared package `definitions` gains:
  - `pc_state_e` (IDLE, RUN, HALTED);
  - constants `PC_W` and `CNT_W`;
  - the 32×PC_W constant array `BRANCH_TGT`, holding the default LUT contents.
- One sub-module, `branch_lut`: a combinational read of `BRANCH_TGT` indexed by Target, producing PC_W bits.
- The next-PC mux, the FSM and the counter live in `pc_fetch`.

## Test plan
- Reset then 3 idle cycles with no Start → PC=0, Done=0, CycleCnt=0 throughout. Assert Reset mid-RUN at PC=7 → PC=0 and state IDLE within the same cycle.
- Start, then 5 cycles with no control → PC sequence 0,1,2,3,4,5. Preload state to PC=1023 and run one cycle → PC=0 (wrap).
- RUN at PC=10:
  - Branch=1, Zero=1, Target=3 → next PC=96;
  - then Branch=1, Zero=0, Target=3 → next PC=97.
- RUN at PC=40:
  - Jump=1, Branch=1, Zero=0, Target=31 → PC=992;
  - then Halt=1 with Jump=1 → PC stays 992 and Done=1 next cycle.
- HALTED:
  - hold 4 cycles → PC=992 and Done=1 stable;
  - then pulse Start → PC=0 and Done=0 on the next edge.
- With `PC_CYCLE_COUNT_EN` defined:
  - Start, 6 RUN cycles, then Halt → CycleCnt=7, held while HALTED; restart clears it to 0.
  - A 70000-cycle run saturates at 65535.
  - Undefined build → CycleCnt=0 always.
